// File: rtl/countdown_pkg.sv
// Shared types and defaults for the round-robin countdown arbiter.
// The optional abort input is enabled by defining COUNTDOWN_ABORT_EN.
package countdown_pkg;

    typedef enum logic [1:0] {
        CD_IDLE,
        CD_COUNT,
        CD_DONE
    } cd_state_t;

    localparam int CNT_W_DEFAULT    = 5;
    localparam int DEFAULT_LOAD_VAL = 8;

endpackage

// File: rtl/countdown_core.sv
// Loadable down-counter that saturates at zero. zero_next means the next
// enabled step leaves the counter at zero.
module countdown_core
    import countdown_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] q,
    output logic             zero_next
);

    logic [CNT_W-1:0] r_q;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= load_val;
        end else if (en && (r_q != '0)) begin
            r_q <= r_q - CNT_W'(1);
        end
    end

    assign q         = r_q;
    assign zero_next = (r_q <= CNT_W'(1));

endmodule

// File: rtl/countdown_arbiter.sv
// Round-robin owner selection for one shared countdown counter.
// Define COUNTDOWN_ABORT_EN to add an abort input that cancels a countdown.
module countdown_arbiter
    import countdown_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int DEFAULT_LOAD = DEFAULT_LOAD_VAL
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] load_val,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [CNT_W-1:0]         q,
    output logic [NUM_REQ-1:0]       done
`ifdef COUNTDOWN_ABORT_EN
   ,input  logic                     abort
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("countdown_arbiter: NUM_REQ must be at least 2");
    end
    if ((DEFAULT_LOAD < 0) || (DEFAULT_LOAD >= (1 << CNT_W))) begin : g_bad_default
        $error("countdown_arbiter: DEFAULT_LOAD does not fit in CNT_W bits");
    end

    // First set request at or after ptr, wrapping; the lowest offset wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   p);
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = p;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NUM_REQ;
            if (r[idx]) pick = IDX_W'(idx);
        end
        return pick;
    endfunction

    cd_state_t          r_state, w_state_next;
    logic [NUM_REQ-1:0] r_grant, w_grant_next;
    logic [NUM_REQ-1:0] r_done,  w_done_next;
    logic               r_busy;
    logic [IDX_W-1:0]   r_ptr,    w_ptr_next;
    logic [IDX_W-1:0]   r_winner, w_winner_next;
    logic [IDX_W-1:0]   w_pick, w_ptr_adv;
    logic [CNT_W-1:0]   w_sel_val, w_load_q, w_core_val, w_q;
    logic               w_load, w_en, w_zero_next;

    assign w_pick    = rr_pick(req, r_ptr);
    assign w_sel_val = load_val[w_pick*CNT_W +: CNT_W];
    assign w_load_q  = (w_sel_val == '0) ? CNT_W'(DEFAULT_LOAD) : w_sel_val;
    assign w_ptr_adv = (r_winner == IDX_W'(NUM_REQ - 1)) ? '0 : r_winner + IDX_W'(1);

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        w_state_next  = r_state;
        w_grant_next  = r_grant;
        w_done_next   = '0;
        w_ptr_next    = r_ptr;
        w_winner_next = r_winner;
        w_load        = 1'b0;
        w_en          = 1'b0;
        w_core_val    = w_load_q;
        unique case (r_state)
            CD_IDLE: begin
                if (|req) begin
                    w_state_next  = CD_COUNT;
                    w_grant_next  = NUM_REQ'(1) << w_pick;
                    w_winner_next = w_pick;
                    w_load        = 1'b1;
                end
            end
            CD_COUNT: begin
`ifdef COUNTDOWN_ABORT_EN
                if (abort) begin
                    // Cancelled countdowns still hand the pointer on to the next requester.
                    w_state_next = CD_IDLE;
                    w_grant_next = '0;
                    w_ptr_next   = w_ptr_adv;
                    w_load       = 1'b1;
                    w_core_val   = '0;
                end else begin
`else
                begin
`endif
                    w_en = 1'b1;
                    if (w_zero_next) begin
                        w_state_next = CD_DONE;
                        w_done_next  = r_grant;
                    end
                end
            end
            CD_DONE: begin
                w_state_next = CD_IDLE;
                w_grant_next = '0;
                w_ptr_next   = w_ptr_adv;
            end
            default: begin
                w_state_next = CD_IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= CD_IDLE;
            r_grant  <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
            r_ptr    <= '0;
            r_winner <= '0;
        end else begin
            r_state  <= w_state_next;
            r_grant  <= w_grant_next;
            r_done   <= w_done_next;
            r_busy   <= (w_state_next != CD_IDLE);
            r_ptr    <= w_ptr_next;
            r_winner <= w_winner_next;
        end
    end

    countdown_core #(
        .CNT_W(CNT_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_core_val),
        .en       (w_en),
        .q        (w_q),
        .zero_next(w_zero_next)
    );

    assign grant = r_grant;
    assign done  = r_done;
    assign busy  = r_busy;
    assign q     = w_q;

endmodule

// File: tb/tb_countdown_arbiter.sv
// Self-checking bench for countdown_arbiter against a transaction-level model.
// Build with COUNTDOWN_ABORT_EN defined to also exercise abort.
module tb_countdown_arbiter;

    localparam int N   = 4;
    localparam int W   = 5;
    localparam int DEF = 8;
    localparam int VW  = 2 * N + 1 + W;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] load_val;
    logic           abort;
    logic [N-1:0]   grant, done;
    logic           busy;
    logic [W-1:0]   q;

    int n_vec = 0;
    int n_err = 0;

    // Model: current owner (-1 when idle), remaining count, pointer, done-cycle flag.
    int m_owner = -1;
    int m_q     = 0;
    int m_ptr   = 0;
    bit m_in_done = 1'b0;

    always #5 clk = ~clk;

    countdown_arbiter #(
        .NUM_REQ(N),
        .CNT_W(W),
        .DEFAULT_LOAD(DEF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .load_val(load_val),
        .grant   (grant),
        .busy    (busy),
        .q       (q),
        .done    (done)
`ifdef COUNTDOWN_ABORT_EN
       ,.abort   (abort)
`endif
    );

    task automatic model_edge();
        int v;
        bit ab;
        ab = 1'b0;
`ifdef COUNTDOWN_ABORT_EN
        ab = abort;
`endif
        if (rst) begin
            m_owner = -1; m_q = 0; m_ptr = 0; m_in_done = 1'b0;
        end else if (m_in_done) begin
            m_in_done = 1'b0;
            m_ptr     = (m_owner + 1) % N;
            m_owner   = -1;
        end else if (m_owner >= 0) begin
            if (ab) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_q     = 0;
            end else begin
                m_q = m_q - 1;
                if (m_q == 0) m_in_done = 1'b1;
            end
        end else if (req != '0) begin
            for (int k = 0; k < N; k++)
                if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            v   = int'(load_val[m_owner*W +: W]);
            m_q = (v == 0) ? DEF : v;
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0] g;
        g = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        return {g, (m_owner >= 0), W'(m_q), (m_in_done ? g : N'(0))};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; load_val = '0; abort = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        req = 4'b0001; load_val = '0; load_val[0 +: W] = 5'd10;
        for (int i = 0; i < 20 && q != 5'd5; i++) begin
            cycle();
            n_vec++;
            if ({grant, busy, q, done} !== exp_vec()) begin
                n_err++;
                $display("FAIL reset_pre: got %h expected %h", {grant, busy, q, done}, exp_vec());
            end
        end
        n_vec++;
        if (q !== 5'd5) begin
            n_err++;
            $display("FAIL reset_reach_q5: got q=%0d expected 5", q);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_vec++;
            if ({grant, busy, q, done} !== {4'b0000, 1'b0, 5'd0, 4'b0000}) begin
                n_err++;
                $display("FAIL reset_hold: got grant=%b busy=%b q=%0d done=%b expected all zero",
                         grant, busy, q, done);
            end
        end
        rst = 1'b0; req = 4'b1111;
        cycle();
        n_vec++;
        if (grant !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_ptr: got grant=%b expected 0001", grant);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001; load_val = '0; load_val[0 +: W] = 5'd3;
        for (int i = 0; i < 7; i++) begin
            cycle();
            if (i == 0) req = '0;
            n_vec++;
            if ({grant, busy, q, done} !== exp_vec()) begin
                n_err++;
                $display("FAIL single cyc%0d: got %h expected %h", i, {grant, busy, q, done}, exp_vec());
            end
        end
    endtask

    task automatic test_rotate();
        logic [N-1:0] seen[$];
        logic [N-1:0] prev;
        logic [N-1:0] want[5];
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        prev = '0;
        req = 4'b1111;
        for (int i = 0; i < N; i++) load_val[i*W +: W] = 5'd1;
        for (int i = 0; i < 15; i++) begin
            cycle();
            n_vec++;
            if ({grant, busy, q, done} !== exp_vec()) begin
                n_err++;
                $display("FAIL rotate cyc%0d: got %h expected %h", i, {grant, busy, q, done}, exp_vec());
            end
            if (prev == '0 && grant != '0) seen.push_back(grant);
            prev = grant;
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (i >= seen.size() || seen[i] !== want[i]) begin
                n_err++;
                $display("FAIL rotate_order%0d: got %b expected %b", i,
                         (i < seen.size()) ? seen[i] : 4'bxxxx, want[i]);
            end
        end
    endtask

    task automatic test_default_load();
        do_reset();
        req = 4'b0001; load_val = '0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (i == 0) req = '0;
            n_vec++;
            if ({grant, busy, q, done} !== exp_vec()) begin
                n_err++;
                $display("FAIL default_load cyc%0d: got %h expected %h", i, {grant, busy, q, done}, exp_vec());
            end
        end
    endtask

    task automatic test_drop_raise();
        bit saw_done0;
        bit got_next;
        saw_done0 = 1'b0; got_next = 1'b0;
        do_reset();
        req = 4'b0001; load_val = '0; load_val[0 +: W] = 5'd6; load_val[2*W +: W] = 5'd2;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (i == 0) req = 4'b0000;
            if (i == 2) req = 4'b0100;
            n_vec++;
            if ({grant, busy, q, done} !== exp_vec()) begin
                n_err++;
                $display("FAIL drop_raise cyc%0d: got %h expected %h", i, {grant, busy, q, done}, exp_vec());
            end
            if (done == 4'b0001) saw_done0 = 1'b1;
            if (saw_done0 && grant == 4'b0100) got_next = 1'b1;
        end
        n_vec++;
        if (!(saw_done0 && got_next)) begin
            n_err++;
            $display("FAIL drop_raise_seq: got done0=%0d grant2=%0d expected 1 1", saw_done0, got_next);
        end
    endtask

`ifdef COUNTDOWN_ABORT_EN
    task automatic test_abort();
        do_reset();
        req = 4'b0001; load_val = '0; load_val[0 +: W] = 5'd7;
        for (int i = 0; i < 12; i++) begin
            cycle();
            req   = (i < 6) ? 4'b0000 : 4'b1111;
            abort = (q == 5'd4 && busy);
            n_vec++;
            if ({grant, busy, q, done} !== exp_vec()) begin
                n_err++;
                $display("FAIL abort cyc%0d: got %h expected %h", i, {grant, busy, q, done}, exp_vec());
            end
        end
        abort = 1'b0;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            req      = N'($urandom_range(0, 15));
            load_val = (N*W)'($urandom);
            for (int j = 0; j < N; j++)
                if ($urandom_range(0, 3) == 0) load_val[j*W +: W] = '0;
`ifdef COUNTDOWN_ABORT_EN
            abort = ($urandom_range(0, 9) == 0);
`endif
            if ($urandom_range(0, 99) == 0) rst = 1'b1;
            cycle();
            rst = 1'b0;
            n_vec++;
            if ({grant, busy, q, done} !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc%0d: got %h expected %h", i, {grant, busy, q, done}, exp_vec());
            end
        end
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; load_val = '0; abort = 1'b0;
        test_reset();
        test_single();
        test_rotate();
        test_default_load();
        test_drop_raise();
`ifdef COUNTDOWN_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
